// File: rtl/systolic_result_drain.sv
// systolic_result_drain: ping-pong capture of 4x4 accumulator tiles,
// requantized (round-half-up, saturate) and streamed row-major.
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 16
`endif
`ifndef SYSTOLIC_FRAC_WIDTH
`define SYSTOLIC_FRAC_WIDTH 8
`endif

module systolic_result_drain #(
  parameter int ACC_WIDTH = `SYSTOLIC_RESULT_WIDTH,
  parameter int OUT_WIDTH = `SYSTOLIC_INPUT_WIDTH,
  parameter int OUT_SHIFT = `SYSTOLIC_FRAC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tile_done,
  input  logic [ACC_WIDTH*16-1:0] tile_result_flat,
  output logic                   buffer_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [3:0]             out_index,
  output logic                   out_last,
  output logic                   out_saturated,
  output logic                   tile_dropped,
  output logic [7:0]             drop_count
);

  localparam int EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] ONE  = 1;
  localparam logic signed [EW-1:0] SMAX = (ONE <<< (OUT_WIDTH-1)) - ONE;
  localparam logic signed [EW-1:0] SMIN = -SMAX - ONE;
  localparam logic [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH*16-1:0] bank_q [2];
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] elem_q, elem_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       tile_dropped_q, tile_dropped_d;

  logic cap, drop, xfer;
  logic [ACC_WIDTH-1:0] acc;
  logic signed [EW-1:0] acc_x, t;

  assign buffer_ready = ~(full_q[0] & full_q[1]);
  assign out_valid    = full_q[rd_ptr_q];
  assign out_index    = elem_q;
  assign out_last     = (elem_q == 4'd15);
  assign tile_dropped = tile_dropped_q;
  assign drop_count   = drop_count_q;

  // Drop is judged on pre-edge flags, even if a bank frees this cycle.
  assign cap  = tile_done & ~full_q[wr_ptr_q];
  assign drop = tile_done & full_q[0] & full_q[1];
  assign xfer = out_valid & out_ready;

  assign acc   = bank_q[rd_ptr_q][elem_q*ACC_WIDTH +: ACC_WIDTH];
  assign acc_x = {acc[ACC_WIDTH-1], acc};

  generate
    if (OUT_SHIFT > 0) begin : g_rnd
      localparam logic signed [EW-1:0] RND = ONE <<< (OUT_SHIFT-1);
      assign t = (acc_x + RND) >>> OUT_SHIFT;
    end else begin : g_nornd
      assign t = acc_x;
    end
  endgenerate

  always_comb begin
    out_saturated = 1'b0;
    out_data      = t[OUT_WIDTH-1:0];
    if (t > SMAX) begin
      out_saturated = 1'b1;
      out_data      = OMAX;
    end else if (t < SMIN) begin
      out_saturated = 1'b1;
      out_data      = OMIN;
    end
  end

  always_comb begin
    full_d         = full_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    elem_d         = elem_q;
    drop_count_d   = drop_count_q;
    tile_dropped_d = 1'b0;
    if (xfer) begin
      elem_d = elem_q + 4'd1;
      if (out_last) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        elem_d           = 4'd0;
      end
    end
    if (cap) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (drop) begin
      tile_dropped_d = 1'b1;
      if (drop_count_q != 8'hFF)
        drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q         <= 2'b00;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      elem_q         <= 4'd0;
      drop_count_q   <= 8'd0;
      tile_dropped_q <= 1'b0;
    end else begin
      full_q         <= full_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      elem_q         <= elem_d;
      drop_count_q   <= drop_count_d;
      tile_dropped_q <= tile_dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap)
      bank_q[wr_ptr_q] <= tile_result_flat;
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: directed table and sequence checks for
// capture, requantization, backpressure, ping-pong, drops and reset.
module tb_systolic_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         tile_done;
  logic [511:0] flat;
  logic         buffer_ready;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_index;
  logic         out_last;
  logic         out_saturated;
  logic         tile_dropped;
  logic [7:0]   drop_count;

  systolic_result_drain #(
    .ACC_WIDTH(32),
    .OUT_WIDTH(16),
    .OUT_SHIFT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tile_done(tile_done),
    .tile_result_flat(flat),
    .buffer_ready(buffer_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .out_saturated(out_saturated),
    .tile_dropped(tile_dropped),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [15:0] d;
    logic        s;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] w[16];
  logic [15:0] ed[16];
  logic        es[16];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int base);
    for (int k = 0; k < 16; k++) begin
      w[k]  = 32'((k + base) * 256);
      ed[k] = 16'(k + base);
      es[k] = 1'b0;
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 16; k++) flat[k*32 +: 32] = w[k];
  endtask

  task automatic send();
    pack();
    tile_done = 1'b1;
    step();
    tile_done = 1'b0;
  endtask

  task automatic beat(input string nm, input int k);
    string s;
    s = $sformatf("%s[%0d]", nm, k);
    chk({s, ".valid"}, 64'(out_valid), 64'd1);
    chk({s, ".index"}, 64'(out_index), 64'(k));
    chk({s, ".data"},  64'(out_data),  64'(ed[k]));
    chk({s, ".last"},  64'(out_last),  64'(k == 15));
    chk({s, ".sat"},   64'(out_saturated), 64'(es[k]));
  endtask

  task automatic drain(input string nm, input int from);
    for (int k = from; k < 16; k++) begin
      beat(nm, k);
      step();
    end
  endtask

  initial begin
    tbl[0]  = '{32'd384,       16'd2,     1'b0};
    tbl[1]  = '{32'hFFFFFE80,  16'hFFFF,  1'b0};
    tbl[2]  = '{32'h7FFFFFFF,  16'h7FFF,  1'b1};
    tbl[3]  = '{32'h80000000,  16'h8000,  1'b1};
    tbl[4]  = '{32'd127,       16'd0,     1'b0};
    tbl[5]  = '{32'd128,       16'd1,     1'b0};
    tbl[6]  = '{32'hFFFFFF80,  16'd0,     1'b0};
    tbl[7]  = '{32'hFFFFFF7F,  16'hFFFF,  1'b0};
    tbl[8]  = '{32'h007FFF7F,  16'h7FFF,  1'b0};
    tbl[9]  = '{32'h00800080,  16'h7FFF,  1'b1};
    tbl[10] = '{32'hFF800000,  16'h8000,  1'b0};
    tbl[11] = '{32'hFF7FFF80,  16'h8000,  1'b0};
    tbl[12] = '{32'hFF7FFF7F,  16'h8000,  1'b1};
    tbl[13] = '{32'd255,       16'd1,     1'b0};
    tbl[14] = '{32'h0003E800,  16'h03E8,  1'b0};
    tbl[15] = '{32'hFFFC1800,  16'hFC18,  1'b0};

    rst = 1'b1;
    tile_done = 1'b0;
    out_ready = 1'b0;
    flat = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst.valid",   64'(out_valid),    64'd0);
    chk("rst.bufrdy",  64'(buffer_ready), 64'd1);
    chk("rst.dropcnt", 64'(drop_count),   64'd0);
    chk("rst.dropped", 64'(tile_dropped), 64'd0);

    // single ramp tile, free-flowing consumer
    set_ramp(0);
    out_ready = 1'b1;
    send();
    for (int k = 0; k < 16; k++) begin
      beat("ramp", k);
      chk($sformatf("ramp[%0d].bufrdy", k), 64'(buffer_ready), 64'd1);
      step();
    end
    chk("ramp.end", 64'(out_valid), 64'd0);

    // rounding / saturation table
    for (int k = 0; k < 16; k++) begin
      w[k]  = tbl[k].acc;
      ed[k] = tbl[k].d;
      es[k] = tbl[k].s;
    end
    send();
    drain("rq", 0);
    chk("rq.end", 64'(out_valid), 64'd0);

    // backpressure at index 3
    set_ramp(0);
    send();
    for (int k = 0; k < 3; k++) begin
      beat("bp", k);
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat("bp_hold", 3);
      step();
    end
    out_ready = 1'b1;
    drain("bp", 3);
    chk("bp.end", 64'(out_valid), 64'd0);

    // ping-pong with a stalled consumer
    out_ready = 1'b0;
    set_ramp(0);
    send();
    step();
    step();
    set_ramp(100);
    send();
    chk("pp.bufrdy_full", 64'(buffer_ready), 64'd0);
    set_ramp(50);
    send();
    chk("pp.dropped",  64'(tile_dropped), 64'd1);
    chk("pp.dropcnt",  64'(drop_count),   64'd1);
    step();
    chk("pp.dropped_clr", 64'(tile_dropped), 64'd0);
    out_ready = 1'b1;
    set_ramp(0);
    for (int k = 0; k < 16; k++) begin
      beat("ppA", k);
      chk($sformatf("ppA[%0d].bufrdy", k), 64'(buffer_ready), 64'd0);
      step();
    end
    chk("pp.bufrdy_freed", 64'(buffer_ready), 64'd1);
    set_ramp(100);
    drain("ppB", 0);
    chk("pp.end", 64'(out_valid), 64'd0);

    // tile_done coincident with A's last beat while B queued
    out_ready = 1'b0;
    set_ramp(0);
    send();
    set_ramp(100);
    send();
    chk("sc.bufrdy_full", 64'(buffer_ready), 64'd0);
    out_ready = 1'b1;
    set_ramp(0);
    for (int k = 0; k < 15; k++) begin
      beat("scA", k);
      step();
    end
    beat("scA", 15);
    set_ramp(50);
    pack();
    tile_done = 1'b1;
    step();
    tile_done = 1'b0;
    chk("sc.dropped", 64'(tile_dropped), 64'd1);
    chk("sc.dropcnt", 64'(drop_count),   64'd2);
    chk("sc.bufrdy",  64'(buffer_ready), 64'd1);
    set_ramp(100);
    drain("scB", 0);
    chk("sc.end", 64'(out_valid), 64'd0);
    chk("sc.dropped_clr", 64'(tile_dropped), 64'd0);

    // drop_count saturation
    out_ready = 1'b0;
    set_ramp(0);
    send();
    send();
    tile_done = 1'b1;
    for (int i = 0; i < 256; i++) step();
    tile_done = 1'b0;
    chk("sat.dropcnt", 64'(drop_count), 64'd255);

    // reset mid-drain at index 7, tile_done coincident with rst
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_ramp(0);
    out_ready = 1'b1;
    send();
    for (int k = 0; k < 7; k++) begin
      beat("rd", k);
      step();
    end
    chk("rd.idx7", 64'(out_index), 64'd7);
    rst = 1'b1;
    tile_done = 1'b1;
    step();
    rst = 1'b0;
    tile_done = 1'b0;
    chk("rd.valid",   64'(out_valid),    64'd0);
    chk("rd.bufrdy",  64'(buffer_ready), 64'd1);
    chk("rd.dropcnt", 64'(drop_count),   64'd0);
    chk("rd.index",   64'(out_index),    64'd0);
    step();
    chk("rd.ignored", 64'(out_valid), 64'd0);
    set_ramp(20);
    send();
    drain("rdC", 0);
    chk("rd.end", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
